// File: rtl/i2c_master_ctrl.sv
// I2C bus master: one-byte register write or register read against a 7-bit slave.
// SCL is push-pull; SDA is open-drain. All bus timing derives from a quarter-bit counter.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_adr,
  input  logic [7:0] mem_adr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl,
  inout  wire        sda
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_TX_BYTE = 3'd2,
    S_RX_ACK  = 3'd3,
    S_RSTART  = 3'd4,
    S_RX_BYTE = 3'd5,
    S_TX_NACK = 3'd6,
    S_STOP    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    P_ADDR_W = 2'd0,
    P_MEM    = 2'd1,
    P_DATA   = 2'd2,
    P_ADDR_R = 2'd3
  } phase_t;

  state_t          r_state;
  phase_t          r_phase;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [7:0]      r_tx;
  logic [6:0]      r_rx;
  logic            r_rw;
  logic [6:0]      r_dev;
  logic [7:0]      r_mem;
  logic [7:0]      r_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_ack_err;
  logic [7:0]      r_rd_data;
  logic            r_scl;
  logic            r_sda_oe;
  logic            r_sda_meta;
  logic            r_sda_sync;

  logic            w_qend;
  logic            w_bend;
  logic            w_scl;
  logic            w_sda_oe;

  assign w_qend  = (r_qcnt == QMAX);
  assign w_bend  = w_qend && (r_q == 2'd3);

  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd_data;
  assign scl     = r_scl;
  assign sda     = r_sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizer on the shared SDA line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_sda_meta <= sda;
      r_sda_sync <= r_sda_meta;
    end
  end

  // Bus line levels for the current state and quarter; Q0 holds SDA from the previous bit
  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = r_sda_oe;
    case (r_state)
      S_IDLE: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
      S_START: begin
        w_scl    = (r_q != 2'd3);
        w_sda_oe = r_q[1];
      end
      S_TX_BYTE: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q == 2'd0) ? r_sda_oe : ~r_tx[7];
      end
      S_RX_ACK, S_RX_BYTE, S_TX_NACK: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q == 2'd0) ? r_sda_oe : 1'b0;
      end
      S_RSTART: begin
        // First bit period parks SCL low and frees SDA; the second forms Sr
        if (r_bit != 3'd0) begin
          w_scl    = 1'b0;
          w_sda_oe = (r_q == 2'd0) ? r_sda_oe : 1'b0;
        end else begin
          w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
          w_sda_oe = r_q[1];
        end
      end
      S_STOP: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_q == 2'd0) ? r_sda_oe : (r_q != 2'd3);
      end
      default: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  // Transaction sequencer, quarter timing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= P_ADDR_W;
      r_qcnt    <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_tx      <= 8'h00;
      r_rx      <= 7'h00;
      r_rw      <= 1'b0;
      r_dev     <= 7'h00;
      r_mem     <= 8'h00;
      r_wdata   <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rd_data <= 8'h00;
      r_scl     <= 1'b1;
      r_sda_oe  <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_scl    <= w_scl;
      r_sda_oe <= w_sda_oe;
      if (r_state != S_IDLE) begin
        r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
        if (w_qend) begin
          r_q <= r_q + 2'd1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rw      <= rw;
            r_dev     <= dev_adr;
            r_mem     <= mem_adr;
            r_wdata   <= wr_data;
            r_ack_err <= 1'b0;
            r_busy    <= 1'b1;
            r_qcnt    <= '0;
            r_q       <= 2'd0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bend) begin
            r_tx    <= {r_dev, 1'b0};
            r_bit   <= 3'd7;
            r_phase <= P_ADDR_W;
            r_state <= S_TX_BYTE;
          end
        end
        S_TX_BYTE: begin
          if (w_bend) begin
            if (r_bit == 3'd0) begin
              r_state <= S_RX_ACK;
            end else begin
              r_bit <= r_bit - 3'd1;
              r_tx  <= {r_tx[6:0], 1'b0};
            end
          end
        end
        S_RX_ACK: begin
          if (w_bend) begin
            if (r_sda_sync) begin
              r_ack_err <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              case (r_phase)
                P_ADDR_W: begin
                  r_tx    <= r_mem;
                  r_bit   <= 3'd7;
                  r_phase <= P_MEM;
                  r_state <= S_TX_BYTE;
                end
                P_MEM: begin
                  if (r_rw) begin
                    r_bit   <= 3'd1;
                    r_state <= S_RSTART;
                  end else begin
                    r_tx    <= r_wdata;
                    r_bit   <= 3'd7;
                    r_phase <= P_DATA;
                    r_state <= S_TX_BYTE;
                  end
                end
                P_ADDR_R: begin
                  r_bit   <= 3'd7;
                  r_state <= S_RX_BYTE;
                end
                default: begin
                  r_state <= S_STOP;
                end
              endcase
            end
          end
        end
        S_RSTART: begin
          if (w_bend) begin
            if (r_bit != 3'd0) begin
              r_bit <= r_bit - 3'd1;
            end else begin
              r_tx    <= {r_dev, 1'b1};
              r_bit   <= 3'd7;
              r_phase <= P_ADDR_R;
              r_state <= S_TX_BYTE;
            end
          end
        end
        S_RX_BYTE: begin
          if (w_bend) begin
            r_rx <= {r_rx[5:0], r_sda_sync};
            if (r_bit == 3'd0) begin
              r_rd_data <= {r_rx, r_sda_sync};
              r_state   <= S_TX_NACK;
            end else begin
              r_bit <= r_bit - 3'd1;
            end
          end
        end
        S_TX_NACK: begin
          if (w_bend) begin
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bend) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C slave at address 7'h4B
// holding a 4-byte memory (AA, 55, AA, CB).
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 5;
  localparam int BIT_CLK = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_adr = 7'h00;
  logic [7:0] mem_adr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;
  logic       scl;
  wire        sda;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state
  logic       slv_oe = 1'b0;
  logic [7:0] slv_mem [4] = '{8'hAA, 8'h55, 8'hAA, 8'hCB};
  logic       slv_active = 1'b0;
  logic       slv_mode = 1'b0;
  logic       slv_rd = 1'b0;
  logic       slv_mnack = 1'b0;
  logic       slv_ack = 1'b0;
  logic [7:0] slv_sh = 8'h00;
  logic [1:0] slv_ptr = 2'd0;
  int         slv_cnt = 0;
  int         slv_byte = 0;
  int         slv_starts = 0;
  int         slv_stops = 0;
  int         slv_mnacks = 0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       c_scl;
  logic       c_sda;

  assign sda = slv_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .dev_adr (dev_adr),
    .mem_adr (mem_adr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rd_data (rd_data),
    .scl     (scl),
    .sda     (sda)
  );

  // Slave: samples the bus on the falling system clock, drives SDA right after SCL falls
  initial forever begin
    @(negedge clk);
    c_scl = scl;
    c_sda = sda;
    if (!rst_n) begin
      slv_oe = 1'b0;
      slv_active = 1'b0;
      slv_cnt = 0;
    end else if (p_scl && c_scl && p_sda && !c_sda) begin
      slv_starts++;
      slv_active = 1'b1;
      slv_cnt = 0;
      slv_byte = 0;
      slv_mode = 1'b0;
      slv_oe = 1'b0;
    end else if (p_scl && c_scl && !p_sda && c_sda) begin
      slv_stops++;
      slv_active = 1'b0;
      slv_oe = 1'b0;
    end else if (slv_active && !p_scl && c_scl) begin
      if (!slv_mode && slv_cnt < 8) slv_sh = {slv_sh[6:0], c_sda};
      if (slv_mode && slv_cnt == 8) begin
        slv_mnack = c_sda;
        if (c_sda) slv_mnacks++;
      end
      slv_cnt++;
    end else if (slv_active && p_scl && !c_scl) begin
      if (slv_cnt == 8) begin
        if (!slv_mode) begin
          case (slv_byte)
            0: begin
              slv_ack = (slv_sh[7:1] == 7'h4B);
              slv_rd  = slv_sh[0];
            end
            1: begin
              slv_ack = (slv_sh < 8'd4);
              slv_ptr = slv_sh[1:0];
            end
            default: begin
              slv_ack = 1'b1;
              slv_mem[slv_ptr] = slv_sh;
            end
          endcase
          slv_byte++;
          slv_oe = slv_ack;
          if (!slv_ack) slv_active = 1'b0;
        end else begin
          slv_oe = 1'b0;
        end
      end else if (slv_cnt == 9) begin
        slv_cnt = 0;
        if (!slv_mode) begin
          slv_oe = 1'b0;
          if (slv_rd && slv_byte == 1) begin
            slv_mode = 1'b1;
            slv_oe = ~slv_mem[slv_ptr][7];
          end
        end else if (slv_mnack) begin
          slv_oe = 1'b0;
          slv_active = 1'b0;
        end else begin
          slv_ptr = slv_ptr + 2'd1;
          slv_oe = ~slv_mem[slv_ptr][7];
        end
      end else if (slv_mode && slv_cnt >= 1) begin
        slv_oe = ~slv_mem[slv_ptr][3'(7 - slv_cnt)];
      end
    end
    p_scl = c_scl;
    p_sda = c_sda;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // One transaction; optionally pulses a conflicting start while busy
  task automatic run_txn(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_mem,
                         input logic [7:0] t_data, input bit abuse,
                         output int cyc, output int pulses, output logic done_at_fall);
    int guard;
    cyc = 0;
    pulses = 0;
    guard = 0;
    @(negedge clk);
    rw = t_rw; dev_adr = t_dev; mem_adr = t_mem; wr_data = t_data; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && guard < 2000) begin
      if (done) pulses++;
      if (abuse && cyc == 100) begin
        start = 1'b1; rw = ~t_rw; dev_adr = 7'h22; mem_adr = 8'hFF; wr_data = 8'h00;
      end else if (abuse && cyc == 101) begin
        start = 1'b0; rw = t_rw; dev_adr = t_dev; mem_adr = t_mem; wr_data = t_data;
      end
      cyc++;
      guard++;
      @(negedge clk);
    end
    done_at_fall = done;
    pulses += int'(done);
    @(negedge clk);
    pulses += int'(done);
  endtask

  int   cyc;
  int   pulses;
  logic dfall;
  int   st0;
  int   nk0;

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check_eq("rst_rd_data", {24'd0, rd_data}, 32'h00);
    check_eq("rst_scl", {31'd0, scl}, 32'd1);
    check_eq("rst_sda", {31'd0, sda}, 32'd1);

    st0 = slv_starts;
    run_txn(1'b0, 7'h4B, 8'h02, 8'h5A, 1'b0, cyc, pulses, dfall);
    check_eq("wr_busy_len", cyc, 29 * BIT_CLK);
    check_eq("wr_done_pulses", pulses, 1);
    check_eq("wr_done_at_fall", {31'd0, dfall}, 32'd1);
    check_eq("wr_ack_err", {31'd0, ack_err}, 32'd0);
    check_eq("wr_mem2", {24'd0, slv_mem[2]}, 32'h5A);
    check_eq("wr_starts", slv_starts - st0, 1);
    check_eq("wr_idle_scl", {31'd0, scl}, 32'd1);
    check_eq("wr_idle_sda", {31'd0, sda}, 32'd1);

    st0 = slv_starts;
    nk0 = slv_mnacks;
    run_txn(1'b1, 7'h4B, 8'h03, 8'h00, 1'b0, cyc, pulses, dfall);
    check_eq("rd_busy_len", cyc, 40 * BIT_CLK);
    check_eq("rd_done_pulses", pulses, 1);
    check_eq("rd_data_cb", {24'd0, rd_data}, 32'hCB);
    check_eq("rd_ack_err", {31'd0, ack_err}, 32'd0);
    check_eq("rd_master_nack", slv_mnacks - nk0, 1);
    check_eq("rd_starts", slv_starts - st0, 2);

    run_txn(1'b0, 7'h4B, 8'h01, 8'h5A, 1'b0, cyc, pulses, dfall);
    check_eq("wr1_mem1", {24'd0, slv_mem[1]}, 32'h5A);
    run_txn(1'b1, 7'h4B, 8'h01, 8'h00, 1'b0, cyc, pulses, dfall);
    check_eq("rd1_data", {24'd0, rd_data}, 32'h5A);

    run_txn(1'b0, 7'h22, 8'h00, 8'h11, 1'b0, cyc, pulses, dfall);
    check_eq("nodev_ack_err", {31'd0, ack_err}, 32'd1);
    check_eq("nodev_busy_len", cyc, 11 * BIT_CLK);
    check_eq("nodev_rd_data", {24'd0, rd_data}, 32'h5A);
    check_eq("nodev_sda", {31'd0, sda}, 32'd1);

    st0 = slv_starts;
    run_txn(1'b1, 7'h4B, 8'h20, 8'h00, 1'b0, cyc, pulses, dfall);
    check_eq("badmem_ack_err", {31'd0, ack_err}, 32'd1);
    check_eq("badmem_busy_len", cyc, 20 * BIT_CLK);
    check_eq("badmem_no_sr", slv_starts - st0, 1);
    check_eq("badmem_rd_data", {24'd0, rd_data}, 32'h5A);

    run_txn(1'b0, 7'h4B, 8'h00, 8'h3C, 1'b1, cyc, pulses, dfall);
    check_eq("abuse_busy_len", cyc, 29 * BIT_CLK);
    check_eq("abuse_mem0", {24'd0, slv_mem[0]}, 32'h3C);
    check_eq("abuse_ack_err_cleared", {31'd0, ack_err}, 32'd0);
    check_eq("abuse_done_pulses", pulses, 1);

    // Reset in the middle of the address byte
    @(negedge clk);
    rw = 1'b0; dev_adr = 7'h4B; mem_adr = 8'h03; wr_data = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_scl", {31'd0, scl}, 32'd1);
    check_eq("arst_sda", {31'd0, sda}, 32'd1);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_rd_data", {24'd0, rd_data}, 32'h00);
    check_eq("arst_mem3_kept", {24'd0, slv_mem[3]}, 32'hCB);

    run_txn(1'b0, 7'h4B, 8'h03, 8'h77, 1'b0, cyc, pulses, dfall);
    check_eq("post_rst_busy_len", cyc, 29 * BIT_CLK);
    check_eq("post_rst_mem3", {24'd0, slv_mem[3]}, 32'h77);
    check_eq("post_rst_ack_err", {31'd0, ack_err}, 32'd0);
    check_eq("post_rst_scl", {31'd0, scl}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Synthesizable single-clock I2C bus master performing one-byte register write or register read transactions against a 7-bit-addressed slave with an 8-bit internal memory address. It sits between a local host handshake (start/busy/done) and the two-wire bus. It drives SCL push-pull (no clock stretching) and SDA open-drain. It is the initiator counterpart to the team's I2C slave model (address 7'h4B, 4-byte memory reset to AA, 55, AA, CB), which is the bench's bus partner.

## Interface
- CLK_DIV, 250: clk cycles per quarter SCL bit period; one bit = 4*CLK_DIV clk (100 kHz at 100 MHz). Legal range ≥ 4.
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only when busy=0
- rw  input  1  1 = register read, 0 = register write; captured with start
- dev_adr  input  7  slave address; captured with start
- mem_adr  input  8  slave memory address byte; captured with start
- wr_data  input  8  write data; captured with start
- busy  output  1  high while a transaction is in progress
- done  output  1  one-cycle pulse at transaction end (success or error)
- ack_err  output  1  set when any slave ACK slot reads 1; cleared on next accepted start
- rd_data  output  8  byte received by the last successful read; held otherwise
- scl  output  1  bus clock, idle high
- sda  inout  1  open-drain: driven 0 or released (z); the bench supplies the pull-up

## Operation
- Reset (async): scl=1, sda released, busy=0, done=0, ack_err=0, rd_data=8'h00, FSM in IDLE. Reset asserted mid-transaction releases both lines immediately. No stop condition is generated.
- Transaction is accepted when start=1 and busy=0. Inputs are captured, ack_err is cleared, and busy rises next cycle. start while busy=1 is ignored.
- Write sequence: S, {dev_adr,0}, ACK, mem_adr, ACK, wr_data, ACK, P.
- Read sequence: S, {dev_adr,0}, ACK, mem_adr, ACK, Sr, {dev_adr,1}, ACK, 8 data bits, master NACK, P.
- FSM states: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP. A byte-phase register selects the next byte to send: ADDR_W, MEM, DATA, ADDR_R.
- A 3-bit down-counter counts bits 7..0. Bytes are sent and received MSB first.
- ACK slot reads sda=1 (NACK): set ack_err, go to STOP. Remaining bytes are skipped, and rd_data is not updated.
- rd_data is loaded only at TX_NACK entry of a read with no prior NACK.
- sda input passes through a 2-flop synchronizer before sampling.

## Timing
- Quarter counter runs 0..CLK_DIV-1. Each bit has quarters Q0..Q3.
- Data/ACK/read bit:
  - Q0: scl=0, sda held.
  - Q1: scl=0, sda updated. Master releases sda for ACK, read and NACK bits.
  - Q2–Q3: scl=1.
  - Sample: synchronized sda on the last clk of Q3.
- START (S, from idle): Q0–Q1 scl=1, sda released; Q2 sda=0, scl=1; Q3 scl=0.
- RSTART (Sr): Q0 scl=0, sda released; Q1 scl=1; Q2 sda=0; Q3 scl=0.
- STOP: Q0 scl=0; Q1 sda=0; Q2 scl=1; Q3 sda released. IDLE follows with scl=1, sda released.
- SDA never changes while scl=1, except in START, RSTART and STOP.
- busy stays high for exactly N*4*CLK_DIV clk. done pulses in the cycle busy falls. N (in bit periods) is:
  - write: 29
  - read: 40
  - NACK on device address: 11
  - NACK on mem_adr: 20
  - NACK on wr_data: 29
  - NACK on read address: 31
- A new start is accepted on the cycle after done, at the earliest.

## Test plan
- Write: dev 4B, mem 02, data 5A -> slave mem[2]=5A; busy for 29*4*CLK_DIV clk; done one pulse; ack_err=0; scl=1 and sda=z afterwards.
- Read: dev 4B, mem 03 -> rd_data=CB; 40 bit periods; master NACK seen on the 9th read-phase bit; ack_err=0.
- Write then read: write 5A to mem 01, then read mem 01 -> rd_data=5A.
- Wrong device: dev 22, write -> ack_err=1 after the first ACK slot; stop issued; busy for 11 bit periods; rd_data unchanged.
- Bad memory address: dev 4B, mem 20, read -> slave NACKs the second byte; ack_err=1; 20 bit periods; no Sr generated.
- Abuse cases:
  - start pulsed while busy=1 -> ignored; captured inputs unchanged.
  - rst_n low mid-byte -> scl=1, sda=z, busy=0 asynchronously.
  - A fresh write after reset completes correctly.
